hazard_pipeline_tracker: RTL and testbench
==========================================

Name: hazard_pipeline_tracker

Overview:
Sequential producer of the destination-register and write-enable information that the hazard/forwarding unit consumes. It takes ID-stage decode fields and the CU_S bubble request, and shifts them through EX, MEM and WB shadow registers. The outputs EX_RD/MEM_RD/WB_RD, the *_Register_File_Enable flags and EX_load_instr feed the hazard unit directly. A stall watchdog FSM flags a pipeline that never un-stalls.

Parameters:
MAX_STALL_CYCLES, 4, consecutive CU_S-high cycles tolerated before hazard_error is raised (valid range 1..255)
STALL_CNT_W, 16, width of the saturating stall counter (used only with the optional feature)

Ports:
clk  input  1  pipeline clock, rising-edge
rst_n  input  1  asynchronous active-low reset
ID_rd  input  5  destination register of the instruction in ID
ID_rf_enable  input  1  ID instruction writes the register file
ID_load_instr  input  1  ID instruction is a load
CU_S  input  1  bubble request from the hazard unit; inserts NOP into EX
ID_flush  input  1  squash request for the ID instruction (taken branch/jump); inserts NOP into EX
EX_RD  output  5  EX-stage destination
MEM_RD  output  5  MEM-stage destination
WB_RD  output  5  WB-stage destination
EX_Register_File_Enable  output  1  EX-stage write enable
MEM_Register_File_Enable  output  1  MEM-stage write enable
WB_Register_File_Enable  output  1  WB-stage write enable
EX_load_instr  output  1  EX-stage instruction is a load
MEM_load_instr  output  1  MEM-stage instruction is a load
hazard_error  output  1  sticky watchdog error
stall_cycles  output  STALL_CNT_W  saturating count of CU_S-high cycles (optional feature only)

Behaviour:
- Reset (rst_n low, async): all RD outputs 5'd0; all enables, load flags and hazard_error 0; FSM in RUN; stall_cycles 0. Outputs must be valid in the same cycle rst_n deasserts.
- The pipeline always advances; there is no freeze of EX/MEM/WB. Per rising edge: WB <= MEM, MEM <= EX, EX <= ID or a bubble. One-cycle latency per stage.
- Bubble into EX when CU_S or ID_flush is 1. A bubble sets EX_RD=0, EX_Register_File_Enable=0 and EX_load_instr=0. Simultaneous CU_S and ID_flush produce a single bubble.
- r0 masking: when ID_rd==0, the EX enable and EX load flag are forced to 0 and EX_RD is captured as 0. This prevents false forwarding and load-use stalls on r0.
- EX_load_instr = ID_load_instr & ID_rf_enable & (ID_rd!=0) & ~bubble. MEM_load_instr shifts from EX_load_instr.
- Watchdog FSM, states RUN/STALL/ERROR, with an 8-bit consecutive-stall counter:
  - RUN: CU_S=1 -> STALL, counter=1.
  - STALL: CU_S=0 -> RUN, counter=0. CU_S=1 -> counter+1; when counter+1 reaches MAX_STALL_CYCLES+1 -> ERROR.
  - ERROR: sticky until reset; hazard_error=1. The pipeline keeps shifting normally.
- A legal load-use stall lasts exactly 1 cycle, so the default of 4 is conservative.
- Reset in mid-stall clears the FSM to RUN and empties all stages.

Optional Feature:
HAZARD_STALL_STATS_EN.
- Defined: the stall_cycles port exists. It increments by 1 every cycle CU_S=1, saturates at all-ones, and is cleared only by reset.
- Not defined: the port is absent and no counter logic is synthesized. Everything else is identical.

Decomposition:
Shared package hazard_pkg holds:
- REG_W=5, REG_ZERO=5'd0
- FSM enum wd_state_t {WD_RUN, WD_STALL, WD_ERROR}
- struct stage_info_t {rd, rf_en, load}

One sub-module, hazard_stage_reg: a single async-reset stage register of stage_info_t with a bubble input, instantiated three times.

Test Plan:
- Reset: hold rst_n=0, drive ID_rd=7, ID_rf_enable=1 -> all outputs 0; after release and 1 clk, EX_RD=7, EX_Register_File_Enable=1.
- Shift: issue rd=3,5,9 on consecutive cycles -> on cycle 3: EX_RD=9, MEM_RD=5, WB_RD=3, all enables 1.
- Load-use bubble: ID load rd=4, then CU_S=1 for 1 cycle -> EX_load_instr=1 for one cycle, then EX enable=0/EX_RD=0 next cycle while MEM_RD=4, MEM_load_instr=1; hazard_error stays 0.
- r0 masking: ID_rd=0, ID_rf_enable=1, ID_load_instr=1 -> EX enable=0, EX_load_instr=0.
- Flush plus stall in the same cycle -> exactly one bubble; the next ID instruction enters EX on the following edge.
- Watchdog: CU_S=1 for 5 cycles with MAX_STALL_CYCLES=4 -> hazard_error rises after the 5th edge and stays 1 after CU_S=0. With HAZARD_STALL_STATS_EN: stall_cycles=5; with STALL_CNT_W=2 it saturates at 3.

Source files
------------

// File: rtl/hazard_pipeline_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the hazard pipeline tracker.
//               Holds the per-stage shadow record and the stall watchdog
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

   localparam int          REG_W    = 5;
   localparam logic [4:0]  REG_ZERO = 5'd0;

   // Stall watchdog states
   typedef enum logic [1:0] {
      WD_RUN   = 2'd0,
      WD_STALL = 2'd1,
      WD_ERROR = 2'd2
   } wd_state_t;

   // Shadow record carried by each of the EX/MEM/WB stages
   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic             rf_en;
      logic             load;
   } stage_info_t;

   // Record representing an empty slot (NOP)
   localparam stage_info_t STAGE_NOP = '{rd: REG_ZERO, rf_en: 1'b0, load: 1'b0};

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_pipeline_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pipeline_tracker_if
// Description : Bundle of ID-stage decode fields, bubble/flush requests and
//               the per-stage outputs consumed by the hazard unit.
//               Optional macro HAZARD_STALL_STATS_EN adds stall_cycles.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_pipeline_tracker_if
   import hazard_pkg::*;
#(
`ifdef HAZARD_STALL_STATS_EN
   parameter int STALL_CNT_W = 16
`endif
);

   // ID-stage side (driven by the decoder / hazard unit)
   logic [REG_W-1:0] ID_rd;
   logic             ID_rf_enable;
   logic             ID_load_instr;
   logic             CU_S;
   logic             ID_flush;

   // Stage shadow outputs (driven by the tracker)
   logic [REG_W-1:0] EX_RD;
   logic [REG_W-1:0] MEM_RD;
   logic [REG_W-1:0] WB_RD;
   logic             EX_Register_File_Enable;
   logic             MEM_Register_File_Enable;
   logic             WB_Register_File_Enable;
   logic             EX_load_instr;
   logic             MEM_load_instr;
   logic             hazard_error;
`ifdef HAZARD_STALL_STATS_EN
   logic [STALL_CNT_W-1:0] stall_cycles;
`endif

`ifdef HAZARD_STALL_STATS_EN
   modport master (
      output ID_rd, ID_rf_enable, ID_load_instr, CU_S, ID_flush,
      input  EX_RD, MEM_RD, WB_RD,
      input  EX_Register_File_Enable, MEM_Register_File_Enable, WB_Register_File_Enable,
      input  EX_load_instr, MEM_load_instr, hazard_error, stall_cycles
   );
   modport slave (
      input  ID_rd, ID_rf_enable, ID_load_instr, CU_S, ID_flush,
      output EX_RD, MEM_RD, WB_RD,
      output EX_Register_File_Enable, MEM_Register_File_Enable, WB_Register_File_Enable,
      output EX_load_instr, MEM_load_instr, hazard_error, stall_cycles
   );
`else
   modport master (
      output ID_rd, ID_rf_enable, ID_load_instr, CU_S, ID_flush,
      input  EX_RD, MEM_RD, WB_RD,
      input  EX_Register_File_Enable, MEM_Register_File_Enable, WB_Register_File_Enable,
      input  EX_load_instr, MEM_load_instr, hazard_error
   );
   modport slave (
      input  ID_rd, ID_rf_enable, ID_load_instr, CU_S, ID_flush,
      output EX_RD, MEM_RD, WB_RD,
      output EX_Register_File_Enable, MEM_Register_File_Enable, WB_Register_File_Enable,
      output EX_load_instr, MEM_load_instr, hazard_error
   );
`endif

endinterface : hazard_pipeline_tracker_if
`default_nettype wire

// File: rtl/hazard_pipeline_tracker_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stage_reg
// Description : One pipeline shadow stage. Captures the upstream record each
//               cycle, or an empty record when a bubble is requested.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stage_reg
   import hazard_pkg::*;
(
   input  wire logic  clk,
   input  wire logic  rst_n,
   input  wire logic  i_bubble,
   input  stage_info_t i_d,
   output stage_info_t o_q
);

   stage_info_t r_q;

   // Stage register: always advances, bubble replaces the incoming record
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= STAGE_NOP;
      end else if (i_bubble) begin
         r_q <= STAGE_NOP;
      end else begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule : hazard_stage_reg
`default_nettype wire

// File: rtl/hazard_pipeline_tracker.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pipeline_tracker
// Description : Shifts ID-stage destination/write-enable/load information
//               through EX, MEM and WB shadow stages for the hazard and
//               forwarding unit, and runs a watchdog that raises a sticky
//               error when CU_S stays high longer than MAX_STALL_CYCLES.
//               Optional macro HAZARD_STALL_STATS_EN adds a saturating
//               count of CU_S-high cycles on stall_cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_pipeline_tracker
   import hazard_pkg::*;
#(
   parameter int MAX_STALL_CYCLES = 4
`ifdef HAZARD_STALL_STATS_EN
   , parameter int STALL_CNT_W = 16
`endif
)(
   input wire logic                 clk,
   input wire logic                 rst_n,
   hazard_pipeline_tracker_if.slave bus
);

   // A run of CU_S cycles becomes an error once its length reaches this
   // value; nine bits so that MAX_STALL_CYCLES = 255 still fits.
   localparam logic [8:0] c_STALL_LIMIT = 9'(MAX_STALL_CYCLES + 1);

   // ------------------------------------------------------------------
   // ID decode into a stage record with r0 masking
   // ------------------------------------------------------------------
   logic        w_bubble;
   logic        w_rd_nonzero;
   stage_info_t w_id_info;
   stage_info_t w_ex;
   stage_info_t w_mem;
   stage_info_t w_wb;
   logic        w_unused_wb_load;

   assign w_bubble     = bus.CU_S | bus.ID_flush;
   assign w_rd_nonzero = (bus.ID_rd != REG_ZERO);

   // Writes to r0 are never real, so they must not look like producers
   assign w_id_info.rd    = w_rd_nonzero ? bus.ID_rd : REG_ZERO;
   assign w_id_info.rf_en = bus.ID_rf_enable & w_rd_nonzero;
   assign w_id_info.load  = bus.ID_load_instr & bus.ID_rf_enable & w_rd_nonzero;

   hazard_stage_reg u_ex_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_bubble (w_bubble),
      .i_d      (w_id_info),
      .o_q      (w_ex)
   );

   hazard_stage_reg u_mem_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_bubble (1'b0),
      .i_d      (w_ex),
      .o_q      (w_mem)
   );

   hazard_stage_reg u_wb_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_bubble (1'b0),
      .i_d      (w_mem),
      .o_q      (w_wb)
   );

   // The hazard unit has no use for the WB load flag
   assign w_unused_wb_load = w_wb.load;

   assign bus.EX_RD                    = w_ex.rd;
   assign bus.MEM_RD                   = w_mem.rd;
   assign bus.WB_RD                    = w_wb.rd;
   assign bus.EX_Register_File_Enable  = w_ex.rf_en;
   assign bus.MEM_Register_File_Enable = w_mem.rf_en;
   assign bus.WB_Register_File_Enable  = w_wb.rf_en;
   assign bus.EX_load_instr            = w_ex.load;
   assign bus.MEM_load_instr           = w_mem.load;

   // ------------------------------------------------------------------
   // Stall watchdog
   // ------------------------------------------------------------------
   wd_state_t   r_wd_state;
   wd_state_t   w_wd_state_nxt;
   logic [7:0]  r_stall_run;
   logic [7:0]  w_stall_run_nxt;
   logic [8:0]  w_stall_run_inc;

   assign w_stall_run_inc = {1'b0, r_stall_run} + 9'd1;

   // Watchdog state and consecutive-stall counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wd_state  <= WD_RUN;
         r_stall_run <= 8'd0;
      end else begin
         r_wd_state  <= w_wd_state_nxt;
         r_stall_run <= w_stall_run_nxt;
      end
   end

   // Watchdog next-state: count consecutive CU_S cycles, trap on overrun
   always_comb begin
      w_wd_state_nxt  = r_wd_state;
      w_stall_run_nxt = r_stall_run;
      case (r_wd_state)
         WD_RUN: begin
            if (bus.CU_S) begin
               w_wd_state_nxt  = WD_STALL;
               w_stall_run_nxt = 8'd1;
            end
         end
         WD_STALL: begin
            if (!bus.CU_S) begin
               w_wd_state_nxt  = WD_RUN;
               w_stall_run_nxt = 8'd0;
            end else begin
               w_stall_run_nxt = w_stall_run_inc[7:0];
               if (w_stall_run_inc == c_STALL_LIMIT) begin
                  w_wd_state_nxt = WD_ERROR;
               end
            end
         end
         WD_ERROR: begin
            w_wd_state_nxt = WD_ERROR;
         end
         default: begin
            w_wd_state_nxt  = WD_RUN;
            w_stall_run_nxt = 8'd0;
         end
      endcase
   end

   assign bus.hazard_error = (r_wd_state == WD_ERROR);

`ifdef HAZARD_STALL_STATS_EN
   // ------------------------------------------------------------------
   // Saturating total of CU_S-high cycles since reset
   // ------------------------------------------------------------------
   logic [STALL_CNT_W-1:0] r_stall_cycles;

   // Count every stalled cycle, holding at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cycles <= '0;
      end else if (bus.CU_S && (r_stall_cycles != {STALL_CNT_W{1'b1}})) begin
         r_stall_cycles <= r_stall_cycles + 1'b1;
      end
   end

   assign bus.stall_cycles = r_stall_cycles;
`endif

endmodule : hazard_pipeline_tracker
`default_nettype wire

// File: tb/tb_hazard_pipeline_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_pipeline_tracker
// Description : Self-checking bench for hazard_pipeline_tracker: directed
//               scenarios followed by random traffic compared against a
//               behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_pipeline_tracker;
   import hazard_pkg::*;

   localparam int MAX = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

`ifdef HAZARD_STALL_STATS_EN
   hazard_pipeline_tracker_if #(.STALL_CNT_W(16)) bus ();
   hazard_pipeline_tracker_if #(.STALL_CNT_W(2))  bus2 ();

   hazard_pipeline_tracker #(.MAX_STALL_CYCLES(MAX), .STALL_CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave));
   hazard_pipeline_tracker #(.MAX_STALL_CYCLES(MAX), .STALL_CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

   assign bus2.ID_rd         = bus.ID_rd;
   assign bus2.ID_rf_enable  = bus.ID_rf_enable;
   assign bus2.ID_load_instr = bus.ID_load_instr;
   assign bus2.CU_S          = bus.CU_S;
   assign bus2.ID_flush      = bus.ID_flush;
`else
   hazard_pipeline_tracker_if bus ();

   hazard_pipeline_tracker #(.MAX_STALL_CYCLES(MAX)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave));
`endif

   int checks   = 0;
   int failures = 0;

   // Reference model: index 0 = EX, 1 = MEM, 2 = WB
   int m_rd [3];
   int m_en [3];
   int m_ld [3];
   int m_run;
   int m_err;
   int m_stalls;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int min_i(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_rd[i] = 0; m_en[i] = 0; m_ld[i] = 0;
      end
      m_run = 0; m_err = 0; m_stalls = 0;
   endtask

   // One rising edge of the reference pipeline, using the inputs now applied
   task automatic model_step();
      int rd, en, ld, bub;
      if (!rst_n) begin
         model_reset();
      end else begin
         bub = (bus.CU_S | bus.ID_flush) ? 1 : 0;
         rd  = int'(bus.ID_rd);
         if (bub != 0) begin
            rd = 0; en = 0; ld = 0;
         end else begin
            en = (bus.ID_rf_enable && rd != 0) ? 1 : 0;
            ld = (en != 0 && bus.ID_load_instr) ? 1 : 0;
         end
         for (int i = 2; i > 0; i--) begin
            m_rd[i] = m_rd[i-1]; m_en[i] = m_en[i-1]; m_ld[i] = m_ld[i-1];
         end
         m_rd[0] = rd; m_en[0] = en; m_ld[0] = ld;
         m_run = bus.CU_S ? m_run + 1 : 0;
         if (m_run > MAX) m_err = 1;
         if (bus.CU_S) m_stalls++;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_ex_rd"},  bus.EX_RD,                    m_rd[0]);
      chk({tag, "_mem_rd"}, bus.MEM_RD,                   m_rd[1]);
      chk({tag, "_wb_rd"},  bus.WB_RD,                    m_rd[2]);
      chk({tag, "_ex_en"},  bus.EX_Register_File_Enable,  m_en[0]);
      chk({tag, "_mem_en"}, bus.MEM_Register_File_Enable, m_en[1]);
      chk({tag, "_wb_en"},  bus.WB_Register_File_Enable,  m_en[2]);
      chk({tag, "_ex_ld"},  bus.EX_load_instr,            m_ld[0]);
      chk({tag, "_mem_ld"}, bus.MEM_load_instr,           m_ld[1]);
      chk({tag, "_herr"},   bus.hazard_error,             m_err);
`ifdef HAZARD_STALL_STATS_EN
      chk({tag, "_stalls"},   bus.stall_cycles,  min_i(m_stalls, 65535));
      chk({tag, "_stalls_w2"}, bus2.stall_cycles, min_i(m_stalls, 3));
`endif
   endtask

   task automatic drive(input int rd, input bit rf, input bit ld, input bit cu, input bit fl);
      bus.ID_rd         = 5'(rd);
      bus.ID_rf_enable  = rf;
      bus.ID_load_instr = ld;
      bus.CU_S          = cu;
      bus.ID_flush      = fl;
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all(tag);
   endtask

   // Asynchronous reset pulse in the middle of a low clock phase
   task automatic async_reset(input string tag);
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_all({tag, "_in"});
      @(negedge clk);
      rst_n = 1'b1;
      check_all({tag, "_rel"});
   endtask

   initial begin
      rst_n = 1'b0;
      drive(7, 1, 0, 0, 0);
      model_reset();

      // Reset held with a live ID instruction
      tick("rst_hold");
      tick("rst_hold");
      chk("rst_ex_rd", bus.EX_RD, 0);
      rst_n = 1'b1;
      check_all("rst_release");
      tick("after_rst");
      chk("after_rst_ex_rd", bus.EX_RD, 7);
      chk("after_rst_ex_en", bus.EX_Register_File_Enable, 1);

      // Shift three producers through the pipe
      drive(3, 1, 0, 0, 0); tick("shift1");
      drive(5, 1, 0, 0, 0); tick("shift2");
      drive(9, 1, 0, 0, 0); tick("shift3");
      chk("shift_ex",  bus.EX_RD,  9);
      chk("shift_mem", bus.MEM_RD, 5);
      chk("shift_wb",  bus.WB_RD,  3);
      chk("shift_wb_en", bus.WB_Register_File_Enable, 1);

      // Load followed by a one-cycle load-use bubble
      drive(4, 1, 1, 0, 0); tick("load");
      chk("load_ex_ld", bus.EX_load_instr, 1);
      drive(11, 1, 0, 1, 0); tick("luse");
      chk("luse_ex_en",  bus.EX_Register_File_Enable, 0);
      chk("luse_ex_rd",  bus.EX_RD, 0);
      chk("luse_mem_rd", bus.MEM_RD, 4);
      chk("luse_mem_ld", bus.MEM_load_instr, 1);
      chk("luse_herr",   bus.hazard_error, 0);

      // r0 destination never looks like a producer
      drive(0, 1, 1, 0, 0); tick("r0");
      chk("r0_ex_en", bus.EX_Register_File_Enable, 0);
      chk("r0_ex_ld", bus.EX_load_instr, 0);

      // Flush and stall together give one bubble
      drive(6, 1, 0, 1, 1); tick("fl_st");
      chk("fl_st_ex_rd", bus.EX_RD, 0);
      drive(8, 1, 0, 0, 0); tick("fl_st_next");
      chk("fl_st_next_ex_rd", bus.EX_RD, 8);
      chk("fl_st_next_mem_rd", bus.MEM_RD, 0);

      // Watchdog from a clean reset: 5 stalled edges trip MAX = 4
      async_reset("wd_rst");
      drive(10, 1, 0, 1, 0);
      for (int i = 0; i < 4; i++) tick("wd_stall");
      chk("wd_herr_4", bus.hazard_error, 0);
      tick("wd_stall5");
      chk("wd_herr_5", bus.hazard_error, 1);
      drive(10, 1, 0, 0, 0); tick("wd_sticky");
      chk("wd_sticky", bus.hazard_error, 1);
      chk("wd_run_ex_rd", bus.EX_RD, 10);
`ifdef HAZARD_STALL_STATS_EN
      chk("wd_stall_cycles", bus.stall_cycles, 5);
      chk("wd_stall_cycles_sat", bus2.stall_cycles, 3);
`endif

      // Reset in mid-stall
      drive(12, 1, 1, 0, 0); tick("pre_mid");
      drive(13, 1, 0, 1, 0); tick("mid_stall"); tick("mid_stall");
      async_reset("mid_rst");
      chk("mid_rst_herr", bus.hazard_error, 0);
      drive(14, 1, 0, 0, 0); tick("mid_after");
      chk("mid_after_ex_rd", bus.EX_RD, 14);

      // Random traffic against the model, with rare resets
      for (int n = 0; n < 600; n++) begin
         drive(int'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 40),
               1'($urandom_range(0, 99) < 10));
         tick("rand");
         if ($urandom_range(0, 149) == 0) async_reset("rand_rst");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_hazard_pipeline_tracker
`default_nettype wire
